// File: rtl/midi_msg_parser.sv
// midi_msg_parser
//   Turns the MIDI byte stream from the UART receiver into monophonic note
//   state for the oscillator tuning lookup (o_note) and the envelope stage
//   (o_gate/o_velocity).
//
//   The parser supports running status, channel filtering, real-time
//   transparency and last-note priority.
//
//   Optional feature macro: MIDI_PITCH_BEND_EN
//     When it is defined, the parser adds the o_pitch_bend and o_bend_stb
//     ports and decodes Ex messages.
//     When it is undefined, Ex messages are parsed and then discarded.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no valid running status, data bytes discarded
// WAIT_D1 | channel status held, expecting data byte 1
// WAIT_D2 | data byte 1 stored, expecting data byte 2
//
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_rx_byte/valid     byte from the UART, one-cycle valid strobe
//   o_note/o_velocity   currently sounding note and its velocity
//   o_gate              high while o_note is held
//   o_evt_note          note number of the latest on/off event
//   o_note_on_stb       1-cycle note-on pulse
//   o_note_off_stb      1-cycle note-off pulse
//   o_pitch_bend        14-bit bend value, 0x2000 = centre (feature build only)
//   o_bend_stb          1-cycle bend update pulse (feature build only)
module midi_msg_parser #(
  parameter int MIDI_CHANNEL = 0,
  parameter bit OMNI         = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic [6:0]  o_note,
  output logic [6:0]  o_velocity,
  output logic        o_gate,
  output logic [6:0]  o_evt_note,
  output logic        o_note_on_stb,
  output logic        o_note_off_stb
`ifdef MIDI_PITCH_BEND_EN
  ,
  output logic [13:0] o_pitch_bend,
  output logic        o_bend_stb
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

  state_t     r_state;
  logic [3:0] r_status;
  logic       r_match;
  logic [6:0] r_d1;

  logic       w_realtime;
  logic       w_syscom;
  logic       w_chan_status;
  logic       w_data;
  logic [6:0] w_d2;
  logic       w_ch_match;

  assign w_realtime    = (i_rx_byte[7:3] == 5'b11111);
  assign w_syscom      = (i_rx_byte[7:3] == 5'b11110);
  assign w_chan_status = i_rx_byte[7] && (i_rx_byte[7:4] != 4'hF);
  assign w_data        = ~i_rx_byte[7];
  assign w_d2          = i_rx_byte[6:0];
  assign w_ch_match    = OMNI || (i_rx_byte[3:0] == 4'(MIDI_CHANNEL));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_status       <= 4'h0;
      r_match        <= 1'b0;
      r_d1           <= 7'd0;
      o_note         <= 7'd0;
      o_velocity     <= 7'd0;
      o_gate         <= 1'b0;
      o_evt_note     <= 7'd0;
      o_note_on_stb  <= 1'b0;
      o_note_off_stb <= 1'b0;
`ifdef MIDI_PITCH_BEND_EN
      o_pitch_bend   <= 14'h2000;
      o_bend_stb     <= 1'b0;
`endif
    end else begin
      o_note_on_stb  <= 1'b0;
      o_note_off_stb <= 1'b0;
`ifdef MIDI_PITCH_BEND_EN
      o_bend_stb     <= 1'b0;
`endif
      // Real-time bytes fall through every branch below untouched.
      if (i_rx_valid && !w_realtime) begin
        if (w_syscom) begin
          r_state <= IDLE;
        end else if (w_chan_status) begin
          r_status <= i_rx_byte[7:4];
          r_match  <= w_ch_match;
          r_state  <= WAIT_D1;
        end else if (w_data) begin
          case (r_state)
            WAIT_D1: begin
              // Cx/Dx are single-data messages with no output effect.
              if (r_status != 4'hC && r_status != 4'hD) begin
                r_d1    <= i_rx_byte[6:0];
                r_state <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              r_state <= WAIT_D1;
              if (r_match) begin
                case (r_status)
                  4'h9, 4'h8: begin
                    if (r_status == 4'h9 && w_d2 != 7'd0) begin
                      o_note        <= r_d1;
                      o_velocity    <= w_d2;
                      o_gate        <= 1'b1;
                      o_evt_note    <= r_d1;
                      o_note_on_stb <= 1'b1;
                    end else begin
                      o_evt_note     <= r_d1;
                      o_note_off_stb <= 1'b1;
                      // Last-note priority: releasing an older note keeps the gate.
                      if (r_d1 == o_note) o_gate <= 1'b0;
                    end
                  end
                  4'hB: begin
                    if (r_d1 == 7'd123 && o_gate) begin
                      o_gate         <= 1'b0;
                      o_evt_note     <= o_note;
                      o_note_off_stb <= 1'b1;
                    end
                  end
`ifdef MIDI_PITCH_BEND_EN
                  4'hE: begin
                    o_pitch_bend <= {w_d2, r_d1};
                    o_bend_stb   <= 1'b1;
                  end
`endif
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  logic [6:0] note, vel, evt, o_note, o_vel, o_evt;
  logic       gate, on_stb, off_stb, o_gate, o_on, o_off;
`ifdef MIDI_PITCH_BEND_EN
  logic [13:0] bend, o_bend;
  logic        bstb, o_bstb;
`endif

  always #5 clk = ~clk;

  midi_msg_parser #(.MIDI_CHANNEL(0), .OMNI(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_note(note), .o_velocity(vel), .o_gate(gate), .o_evt_note(evt),
    .o_note_on_stb(on_stb), .o_note_off_stb(off_stb)
`ifdef MIDI_PITCH_BEND_EN
    , .o_pitch_bend(bend), .o_bend_stb(bstb)
`endif
  );

  midi_msg_parser #(.MIDI_CHANNEL(0), .OMNI(1'b1)) dut_omni (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_note(o_note), .o_velocity(o_vel), .o_gate(o_gate), .o_evt_note(o_evt),
    .o_note_on_stb(o_on), .o_note_off_stb(o_off)
`ifdef MIDI_PITCH_BEND_EN
    , .o_pitch_bend(o_bend), .o_bend_stb(o_bstb)
`endif
  );

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        on, off, g;
    logic [6:0]  n, vl, e;
    logic        bs;
    logic [13:0] bd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic v, input logic on, input logic off,
                     input logic g, input int n, input int vl, input int e,
                     input logic bs, input logic [13:0] bd);
    vec_t x;
    x.b = b; x.v = v; x.on = on; x.off = off; x.g = g;
    x.n = 7'(n); x.vl = 7'(vl); x.e = 7'(e); x.bs = bs; x.bd = bd;
    vecs.push_back(x);
  endtask

  // Shorthand for a valid byte with the bend left at centre.
  task automatic a(input logic [7:0] b, input logic on, input logic off, input logic g,
                   input int n, input int vl, input int e);
    add(b, 1'b1, on, off, g, n, vl, e, 1'b0, 14'h2000);
  endtask

  task automatic step(input int idx, input vec_t v);
    vec_t x;
    @(negedge clk);
    rx_byte  = v.b;
    rx_valid = v.v;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk($sformatf("v%0d_on", idx),   32'(on_stb),  32'(x.on));
    chk($sformatf("v%0d_off", idx),  32'(off_stb), 32'(x.off));
    chk($sformatf("v%0d_gate", idx), 32'(gate),    32'(x.g));
    chk($sformatf("v%0d_note", idx), 32'(note),    32'(x.n));
    chk($sformatf("v%0d_vel", idx),  32'(vel),     32'(x.vl));
    chk($sformatf("v%0d_evt", idx),  32'(evt),     32'(x.e));
`ifdef MIDI_PITCH_BEND_EN
    chk($sformatf("v%0d_bstb", idx), 32'(bstb), 32'(x.bs));
    chk($sformatf("v%0d_bend", idx), 32'(bend), 32'(x.bd));
`endif
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_note"}, 32'(note), 0);
    chk({tag, "_vel"},  32'(vel), 0);
    chk({tag, "_gate"}, 32'(gate), 0);
    chk({tag, "_evt"},  32'(evt), 0);
    chk({tag, "_on"},   32'(on_stb), 0);
    chk({tag, "_off"},  32'(off_stb), 0);
    chk({tag, "_ogate"}, 32'(o_gate), 0);
`ifdef MIDI_PITCH_BEND_EN
    chk({tag, "_bend"}, 32'(bend), 32'h2000);
    chk({tag, "_bstb"}, 32'(bstb), 0);
`endif
  endtask

  initial begin
    // note-on then explicit note-off
    a(8'h90,0,0,0, 0,  0, 0);  a(8'h3C,0,0,0, 0,  0, 0);  a(8'h64,1,0,1,60,100,60);
    a(8'h80,0,0,1,60,100,60);  a(8'h3C,0,0,1,60,100,60);  a(8'h00,0,1,0,60,100,60);
    // running status, last-note priority
    a(8'h90,0,0,0,60,100,60);  a(8'h3C,0,0,0,60,100,60);  a(8'h64,1,0,1,60,100,60);
    a(8'h40,0,0,1,60,100,60);  a(8'h50,1,0,1,64, 80,64);
    a(8'h3C,0,0,1,64, 80,64);  a(8'h00,0,1,1,64, 80,60);
    // all notes off, with gate high then with gate low
    a(8'hB0,0,0,1,64, 80,60);  a(8'h7B,0,0,1,64, 80,60);  a(8'h00,0,1,0,64, 80,64);
    a(8'hB0,0,0,0,64, 80,64);  a(8'h7B,0,0,0,64, 80,64);  a(8'h00,0,0,0,64, 80,64);
    // real-time bytes mid-message
    a(8'h90,0,0,0,64, 80,64);  a(8'hF8,0,0,0,64, 80,64);  a(8'h3C,0,0,0,64, 80,64);
    a(8'hFE,0,0,0,64, 80,64);  a(8'h64,1,0,1,60,100,60);
    // SysEx clears running status
    a(8'h90,0,0,1,60,100,60);  a(8'h3C,0,0,1,60,100,60);  a(8'hF0,0,0,1,60,100,60);
    a(8'h64,0,0,1,60,100,60);  a(8'hF7,0,0,1,60,100,60);  a(8'h3C,0,0,1,60,100,60);
    a(8'h64,0,0,1,60,100,60);
    // invalid cycle inside a message must be ignored
    a(8'h90,0,0,1,60,100,60);  a(8'h3E,0,0,1,60,100,60);
    add(8'h00, 1'b0, 0,0,1,60,100,60, 1'b0, 14'h2000);
    a(8'h40,1,0,1,62, 64,62);
    // other channel filtered
    a(8'h91,0,0,1,62, 64,62);  a(8'h3E,0,0,1,62, 64,62);  a(8'h00,0,0,1,62, 64,62);
    a(8'h81,0,0,1,62, 64,62);  a(8'h3E,0,0,1,62, 64,62);  a(8'h00,0,0,1,62, 64,62);
    // new status aborts pending message
    a(8'h90,0,0,1,62, 64,62);  a(8'h3D,0,0,1,62, 64,62);  a(8'h80,0,0,1,62, 64,62);
    a(8'h3E,0,0,1,62, 64,62);  a(8'h00,0,1,0,62, 64,62);
    // Cx consumed, then note-on, then retrigger by running status
    a(8'hC0,0,0,0,62, 64,62);  a(8'h05,0,0,0,62, 64,62);  a(8'h90,0,0,0,62, 64,62);
    a(8'h3C,0,0,0,62, 64,62);  a(8'h7F,1,0,1,60,127,60);
    a(8'h3C,0,0,1,60,127,60);  a(8'h20,1,0,1,60, 32,60);
    // off of a non-current note, then of the current one
    a(8'h80,0,0,1,60, 32,60);  a(8'h3E,0,0,1,60, 32,60);  a(8'h00,0,1,1,60, 32,62);
    a(8'h3C,0,0,1,60, 32,62);  a(8'h40,0,1,0,60, 32,60);
    // pitch bend (only observable with the feature built in)
    a(8'hE0,0,0,0,60, 32,60);  a(8'h00,0,0,0,60, 32,60);
    add(8'h40, 1'b1, 0,0,0,60,32,60, 1'b1, 14'h2000);
    add(8'h7F, 1'b1, 0,0,0,60,32,60, 1'b0, 14'h2000);
    add(8'h7F, 1'b1, 0,0,0,60,32,60, 1'b1, 14'h3FFF);
    add(8'h01, 1'b1, 0,0,0,60,32,60, 1'b0, 14'h3FFF);
    add(8'h00, 1'b1, 0,0,0,60,32,60, 1'b1, 14'h0001);

    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // reset in the middle of a message discards the status byte
    drive(8'h90);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h3C);
    drive(8'h64);
    chk("rst_nostb", 32'(on_stb), 0);
    chk("rst_nogate", 32'(gate), 0);
    chk("rst_omni_nostb", 32'(o_on), 0);

    // channel 1 note: filtered by the fixed-channel parser, accepted by omni
    drive(8'h91);
    drive(8'h3C);
    drive(8'h64);
    chk("ch1_on", 32'(on_stb), 0);
    chk("ch1_gate", 32'(gate), 0);
    chk("omni_on", 32'(o_on), 1);
    chk("omni_note", 32'(o_note), 60);
    chk("omni_vel", 32'(o_vel), 100);
    chk("omni_gate", 32'(o_gate), 1);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("omni_on_1cyc", 32'(o_on), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
